// File: rtl/ascon_permutation.sv
// Ascon-p permutation engine: one round per clock (two with ASCON_PERM_UNROLL2_EN defined).
// Round constants and the 5-bit S-box live in ascon_pkg, shared by every round datapath.
package ascon_pkg;
    typedef logic [3:0] rnd_t;

    // Entries 12..15 are never reached; they pad the table to the index width.
    localparam logic [7:0] RndConst [16] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
        8'h78, 8'h69, 8'h5a, 8'h4b, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [4:0] Sbox [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input rnd_t idx);
        logic [63:0] x [5];
        logic [63:0] t [5];
        logic [4:0]  w;
        x[0] = s[319:256];
        x[1] = s[255:192];
        x[2] = s[191:128];
        x[3] = s[127:64];
        x[4] = s[63:0];
        x[2][7:0] = x[2][7:0] ^ RndConst[idx];
        // Bit-sliced S-box: column i of the five words is one 5-bit symbol, x0 as MSB.
        for (int i = 0; i < 64; i++) begin
            w = Sbox[{x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]}];
            t[0][i] = w[4];
            t[1][i] = w[3];
            t[2][i] = w[2];
            t[3][i] = w[1];
            t[4][i] = w[0];
        end
        x[0] = t[0] ^ ror64(t[0], 19) ^ ror64(t[0], 28);
        x[1] = t[1] ^ ror64(t[1], 61) ^ ror64(t[1], 39);
        x[2] = t[2] ^ ror64(t[2], 1)  ^ ror64(t[2], 6);
        x[3] = t[3] ^ ror64(t[3], 10) ^ ror64(t[3], 17);
        x[4] = t[4] ^ ror64(t[4], 7)  ^ ror64(t[4], 41);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction
endpackage

module ascon_permutation
    import ascon_pkg::*;
#(
    parameter int PA_ROUNDS = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  rnd_t         rounds_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         done_o
);
    // Handshake: start_i is taken only in IDLE (busy_o=0), sampling rounds_i and
    // state_i on that edge; busy_o (the FSM state, IDLE=0/RUN=1) stays high until
    // the last round is written, and done_o pulses for the single following cycle,
    // during which a new start_i is already accepted.
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

    localparam rnd_t PaRnd = rnd_t'(PA_ROUNDS);

    fsm_t         fsm_q, fsm_d;
    logic [319:0] state_q, state_d;
    rnd_t         idx_q, idx_d;
    rnd_t         rem_q, rem_d;
    logic         done_q, done_d;
    rnd_t         n_sel;
    logic [319:0] round1;

    assign n_sel  = (rounds_i == 4'd0 || rounds_i > PaRnd) ? PaRnd : rounds_i;
    assign round1 = ascon_round(state_q, idx_q);

`ifdef ASCON_PERM_UNROLL2_EN
    logic [319:0] round2;
    assign round2 = ascon_round(round1, idx_q + 4'd1);
`endif

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d = state_i;
                    idx_d   = 4'd12 - n_sel;
                    rem_d   = n_sel;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
`ifdef ASCON_PERM_UNROLL2_EN
                if (rem_q >= 4'd2) begin
                    state_d = round2;
                    idx_d   = idx_q + 4'd2;
                    rem_d   = rem_q - 4'd2;
                end else begin
                    state_d = round1;
                    idx_d   = idx_q + 4'd1;
                    rem_d   = rem_q - 4'd1;
                end
`else
                state_d = round1;
                idx_d   = idx_q + 4'd1;
                rem_d   = rem_q - 4'd1;
`endif
                if (rem_d == 4'd0) begin
                    fsm_d  = IDLE;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = (fsm_q == RUN);
    assign done_o  = done_q;
endmodule

// File: tb/tb_ascon_permutation.sv
// Self-checking bench for ascon_permutation: vector table, random ops against a
// word-level Ascon-p model, plus busy-start, back-to-back and mid-run reset sequences.
module tb_ascon_permutation;
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [3:0]   rounds_i = '0;
    logic [319:0] state_i = '0;
    logic [319:0] state_o;
    logic         busy_o;
    logic         done_o;

    int total = 0;
    int bad = 0;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    localparam logic [319:0] VEC1 = {64'h000964B00000004B, 64'h0000000096000213,
                                     64'h53FFFFFFFFFFFF90, 64'h12E580000000004B, 64'h0};

    ascon_permutation #(.PA_ROUNDS(12)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .rounds_i(rounds_i),
        .state_i (state_i),
        .state_o (state_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int eff_rounds(input int r);
        return (r == 0 || r > 12) ? 12 : r;
    endfunction

    function automatic int exp_lat(input int r);
`ifdef ASCON_PERM_UNROLL2_EN
        return (eff_rounds(r) + 1) / 2;
`else
        return eff_rounds(r);
`endif
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference Ascon-p: round r uses constant ((15-r)<<4)|r, then S-box columns, then linear mix.
    function automatic logic [319:0] golden(input logic [319:0] s, input int r_req);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  sym;
        int          n;
        int          rot_a [5] = '{19, 61, 1, 10, 7};
        int          rot_b [5] = '{28, 39, 6, 17, 41};
        n = eff_rounds(r_req);
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        for (int r = 12 - n; r < 12; r++) begin
            x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                sym = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
                for (int w = 0; w < 5; w++) y[w][b] = sym[4 - w];
            end
            for (int w = 0; w < 5; w++) x[w] = y[w] ^ rotr(y[w], rot_a[w]) ^ rotr(y[w], rot_b[w]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start one op from IDLE; optionally pulse start_i with other_s at cycle pulse_at while busy.
    task automatic run_op(input logic [319:0] s, input logic [3:0] r, input int pulse_at,
                          input logic [319:0] other_s, output logic [319:0] res,
                          output int lat, output logic busy_first);
        state_i = s;
        rounds_i = r;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        busy_first = busy_o;
        lat = 0;
        while (!done_o && lat < 100) begin
            start_i = (lat == pulse_at);
            if (lat == pulse_at) begin
                state_i = other_s;
                rounds_i = 4'd1;
            end
            @(posedge clk_i); #1;
            lat++;
        end
        start_i = 1'b0;
        res = state_o;
    endtask

    typedef struct {
        logic [319:0] st;
        logic [3:0]   rnd;
        logic [319:0] exp_st;
        int           lat;
    } vec_t;

    vec_t         vecs[8];
    logic [319:0] exp_q[$];
    logic [319:0] res;
    logic [319:0] held;
    logic [319:0] s;
    logic [3:0]   rr;
    int           lat;
    int           c;
    int           dones;
    logic         bf;

    initial begin
        vecs[0] = '{'0, 4'd1, VEC1, exp_lat(1)};
        vecs[1] = '{rand320(), 4'd12, '0, exp_lat(12)};
        vecs[2] = '{rand320(), 4'd6, '0, exp_lat(6)};
        vecs[3] = '{rand320(), 4'd0, '0, exp_lat(0)};
        vecs[4] = '{rand320(), 4'd7, '0, exp_lat(7)};
        vecs[5] = '{rand320(), 4'd13, '0, exp_lat(13)};
        vecs[6] = '{rand320(), 4'd15, '0, exp_lat(15)};
        vecs[7] = '{'0, 4'd12, '0, exp_lat(12)};
        for (int i = 1; i < 8; i++) vecs[i].exp_st = golden(vecs[i].st, int'(vecs[i].rnd));

        #12;
        check("reset_state", state_o, '0);
        check("reset_busy", 320'(busy_o), 320'd0);
        check("reset_done", 320'(done_o), 320'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].st, vecs[i].rnd, -1, '0, res, lat, bf);
            check($sformatf("vec%0d_state", i), res, vecs[i].exp_st);
            check($sformatf("vec%0d_lat", i), 320'(lat), 320'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i), 320'(bf), 320'd1);
            @(posedge clk_i); #1;
            check($sformatf("vec%0d_done_once", i), 320'({busy_o, done_o}), 320'd0);
        end

        held = state_o;
        state_i = rand320();
        repeat (5) @(posedge clk_i);
        #1;
        check("idle_hold", state_o, held);

        s = rand320();
        run_op(s, 4'd12, 5, rand320(), res, lat, bf);
        check("busy_start_state", res, golden(s, 12));
        check("busy_start_lat", 320'(lat), 320'(exp_lat(12)));
        @(posedge clk_i); #1;
        check("busy_start_no_restart", 320'(busy_o), 320'd0);

        for (int k = 0; k < 20; k++) begin
            s = rand320();
            rr = 4'($urandom_range(0, 15));
            run_op(s, rr, -1, '0, res, lat, bf);
            check($sformatf("rand%0d_state_r%0d", k, rr), res, golden(s, int'(rr)));
            check($sformatf("rand%0d_lat", k), 320'(lat), 320'(exp_lat(int'(rr))));
        end

        s = rand320();
        state_i = s;
        rounds_i = 4'd6;
        start_i = 1'b1;
        exp_q.push_back(golden(s, 6));
        @(posedge clk_i); #1;
        for (int k = 0; k < 4; k++) begin
            c = 0;
            while (!done_o && c < 100) begin
                @(posedge clk_i); #1;
                c++;
            end
            check($sformatf("b2b%0d_period", k), 320'(c + 1), 320'(exp_lat(6) + 1));
            check($sformatf("b2b%0d_state", k), state_o, exp_q.pop_front());
            if (k < 3) begin
                s = rand320();
                state_i = s;
                exp_q.push_back(golden(s, 6));
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i); #1;
        end

        state_i = rand320();
        rounds_i = 4'd12;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_state", state_o, '0);
        check("midrst_busy", 320'(busy_o), 320'd0);
        check("midrst_done", 320'(done_o), 320'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) dones++;
        end
        check("midrst_no_done", 320'(dones), 320'd0);
        run_op('0, 4'd1, -1, '0, res, lat, bf);
        check("midrst_vec1_state", res, VEC1);
        check("midrst_vec1_lat", 320'(lat), 320'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ascon_permutation.md
ASCON_PERMUTATION -- requirements
Module: ascon_permutation

Interface
REQ-001 SHALL have parameter PA_ROUNDS, default 12, giving the maximum and fallback round count.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start_i, input, 1, a request to permute state_i, sampled on the clock edge.
REQ-005 SHALL have port rounds_i, input, 4 (rnd_t), the number of rounds, sampled with start_i.
REQ-006 SHALL have port state_i, input, 320, the input state: x0=[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0].
REQ-007 SHALL have port state_o, output, 320, the state register, with the same word mapping as state_i.
REQ-008 SHALL have port busy_o, output, 1, high while rounds remain to be applied.
REQ-009 SHALL have port done_o, output, 1, a one-cycle pulse when the final round has been applied.

Function
REQ-010 SHALL have two states, IDLE and RUN; reset enters IDLE.
REQ-011 SHALL, in IDLE with start_i=1, load state_i into the state register, latch N and the round index, and move to RUN.
- N = rounds_i, but N = PA_ROUNDS when rounds_i = 0 or rounds_i > PA_ROUNDS.
- The round index starts at 12-N.
REQ-012 SHALL ignore start_i while busy_o=1; inputs are not re-sampled.
REQ-013 SHALL, in RUN, apply exactly one round per clock edge and increment the round index after each round.
REQ-014 SHALL build each round from the package tables, in this order:
- Constant addition: x2[7:0] ^= RndConst[index].
- Substitution: for each bit i, a 5-bit word {x0[i],x1[i],x2[i],x3[i],x4[i]} (x0 is the MSB) is replaced by Sbox[word].
- Linear layer, with 64-bit right rotation:
  - x0 ^= ror19 ^ ror28
  - x1 ^= ror61 ^ ror39
  - x2 ^= ror1 ^ ror6
  - x3 ^= ror10 ^ ror17
  - x4 ^= ror7 ^ ror41
REQ-015 SHALL, for a start accepted at edge t, meet this timing:
- busy_o is 1 from edge t to edge t+N.
- The last round is written at edge t+N.
- done_o is 1 for exactly the cycle after edge t+N.
- The FSM is back in IDLE after edge t+N.
REQ-016 SHALL hold state_o unchanged in IDLE until the next accepted start.
REQ-017 SHALL accept a start_i that is high in the done_o cycle, at the edge that ends that cycle, with no idle gap.

Reset
REQ-018 SHALL, on rst_ni=0, immediately clear the following, independent of clk_i:
- state register (state_o = 0)
- round index
- counters
- busy_o
- done_o
REQ-019 SHALL, when reset is asserted mid-RUN, abort the operation and not pulse done_o; the first start after release behaves as from power-up.

Configuration
REQ-020 SHALL, with ASCON_PERM_UNROLL2_EN defined, apply two consecutive rounds per edge in RUN.
- An odd N applies one round on its final edge.
- busy_o/done_o latency becomes ceil(N/2).
- Results are identical to the single-round build.
REQ-021 SHALL, without ASCON_PERM_UNROLL2_EN, instantiate only one round datapath, with latency N.

Verification
REQ-022 SHALL check the single-round vector: state_i=0, rounds_i=1 -> done_o at edge t+1, with:
- x0=0x000964B00000004B
- x1=0x0000000096000213
- x2=0x53FFFFFFFFFFFF90
- x3=0x12E580000000004B
- x4=0
REQ-023 SHALL check latency: rounds_i=12, then 6, then 0 -> done_o 12, 6 and 12 cycles after start (6, 3 and 6 with UNROLL2); state_o matches the golden Ascon-p model.
REQ-024 SHALL check that a start_i pulse with different state_i while busy_o=1 (rounds_i=12, pulse at cycle 5) leaves the result and latency unchanged.
REQ-025 SHALL check back-to-back operation: start_i held high continuously with rounds_i=6 -> done_o every 7 cycles, each result equal to the golden model.
REQ-026 SHALL check mid-operation reset: rst_ni low for 1 cycle at round 4 of 12 -> state_o=0, busy_o=0, no done_o; the next start with rounds_i=1 on zero state reproduces REQ-022.
